// File: rtl/reg_dump_scanner.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_dump_scanner : streams register-file words read via the test port.
// Option macro REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
// Revision: 1.0
// ---------------------------------------------------------------------------
module reg_dump_scanner #(
  parameter int NUM_REGS  = 32,
  parameter int FIRST_REG = 0,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic [ADDR_W-1:0] test_addr,
  input  logic [DATA_W-1:0] test_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] C_FIRST_ADDR = ADDR_W'(FIRST_REG);
  localparam logic [ADDR_W-1:0] C_LAST_ADDR  = ADDR_W'(NUM_REGS - 1);

`ifdef REG_DUMP_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, SEND, CSUM} state_t;
  logic [DATA_W-1:0] r_csum, w_csum;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
`endif

  state_t            r_state, w_state;
  logic [ADDR_W-1:0] w_addr, w_index;
  logic [DATA_W-1:0] w_data;
  logic              w_valid, w_last, w_busy, w_done;
  logic              w_hs, w_at_end;

  assign w_hs     = out_valid & out_ready;
  // test_addr stays on the register being presented, so it identifies the final beat.
  assign w_at_end = (test_addr == C_LAST_ADDR);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= IDLE;
      test_addr <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      r_state   <= w_state;
      test_addr <= w_addr;
      out_valid <= w_valid;
      out_data  <= w_data;
      out_index <= w_index;
      out_last  <= w_last;
      busy      <= w_busy;
      done      <= w_done;
`ifdef REG_DUMP_CHECKSUM_EN
      r_csum    <= w_csum;
`endif
    end
  end

  always_comb begin
    w_state = r_state;
    w_addr  = test_addr;
    w_valid = out_valid;
    w_data  = out_data;
    w_index = out_index;
    w_last  = out_last;
    w_busy  = busy;
    w_done  = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
    w_csum  = r_csum;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_addr  = C_FIRST_ADDR;
          w_busy  = 1'b1;
          w_state = LOAD;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum  = '0;
`endif
        end
      end
      LOAD: begin
        w_data  = test_data;
        w_index = test_addr;
`ifdef REG_DUMP_CHECKSUM_EN
        w_last  = 1'b0;
`else
        w_last  = w_at_end;
`endif
        w_valid = 1'b1;
        w_state = SEND;
      end
      SEND: begin
        if (w_hs) begin
          w_valid = 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
          w_csum  = r_csum ^ out_data;
`endif
          if (!w_at_end) begin
            w_addr  = test_addr + ADDR_W'(1);
            w_state = LOAD;
          end else begin
`ifdef REG_DUMP_CHECKSUM_EN
            // Checksum beat follows immediately with the final folded value.
            w_data  = r_csum ^ out_data;
            w_index = '0;
            w_last  = 1'b1;
            w_valid = 1'b1;
            w_state = CSUM;
`else
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_state = IDLE;
`endif
          end
        end
      end
`ifdef REG_DUMP_CHECKSUM_EN
      CSUM: begin
        if (w_hs) begin
          w_valid = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = IDLE;
        end
      end
`endif
      default: w_state = IDLE;
    endcase
  end

endmodule
`default_nettype wire
